seq_divider: RTL and testbench

// Multi-cycle unsigned divider using repeated subtraction; the inverse of the

---
 rtl/seq_divider_if.sv | 26 ++
 rtl/seq_divider.sv | 108 ++++++++++
 tb/tb_seq_divider.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
interface seq_divider_if #(
    parameter int WIDTH = 6,
    parameter int DW    = 2
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [DW-1:0]    divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [DW-1:0]    remainder;
    logic             div_by_zero;

    // Requester side: issues operands, observes status and results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned divider: one guarded subtraction per clock, counting
// subtractions into the quotient. Results are returned through a
// start/busy/done handshake and held until the next completion.
module seq_divider #(
    parameter int WIDTH = 6,
    parameter int DW    = 2
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [DW-1:0]    dvs;
    logic [WIDTH-1:0] dvs_ext;
    logic             acc_ge;
    logic [WIDTH-1:0] quotient_r;
    logic [DW-1:0]    remainder_r;
    logic             dbz_r;

    assign dvs_ext = {{(WIDTH-DW){1'b0}}, dvs};
    assign acc_ge  = (acc >= dvs_ext);

    // State register; reset abandons any in-flight operation without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode: zero divisor bypasses RUN, RUN exits once acc < divisor.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = (bus.divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!acc_ge) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, subtract-and-count, result latch on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            q           <= '0;
            dvs         <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            acc   <= bus.dividend;
                            q     <= '0;
                            dvs   <= bus.divisor;
                            dbz_r <= 1'b0;
                        end else begin
                            quotient_r  <= '1;
                            remainder_r <= '0;
                            dbz_r       <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (acc_ge) begin
                        // Guarded by the compare, so acc never underflows and
                        // q is bounded by the dividend.
                        acc <= acc - dvs_ext;
                        q   <= q + WIDTH'(1);
                    end else begin
                        quotient_r  <= q;
                        remainder_r <= acc[DW-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // All outputs come straight from registers or the state register.
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider with a result scoreboard.
module tb_seq_divider;
    localparam int WIDTH = 6;
    localparam int DW    = 2;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [DW-1:0]    r;
        logic             z;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   done_cnt;
    int   exp_done_cnt;
    exp_t sb[$];

    seq_divider_if #(.WIDTH(WIDTH), .DW(DW)) bus ();

    seq_divider #(.WIDTH(WIDTH), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse, so spurious or missing completions show up.
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request and queue the result the bench expects from it.
    task automatic start_op(input int dvd, input int dvs, input int qe, input int re, input bit ze);
        exp_t e;
        e.q = qe[WIDTH-1:0];
        e.r = re[DW-1:0];
        e.z = ze;
        sb.push_back(e);
        bus.start    = 1'b1;
        bus.dividend = dvd[WIDTH-1:0];
        bus.divisor  = dvs[DW-1:0];
    endtask

    // Pass edge E0, wait for done, compare latency and the scoreboard head,
    // then confirm the return to IDLE. With hold set, a 9/2 request is kept
    // asserted through RUN and DONE.
    task automatic finish_op(input string tag, input int lat_exp, input bit hold);
        int   lat;
        exp_t e;
        tick();
        if (hold) begin
            bus.start    = 1'b1;
            bus.dividend = WIDTH'(9);
            bus.divisor  = DW'(2);
        end else begin
            bus.start = 1'b0;
        end
        lat = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, lat_exp);
        if (bus.done === 1'b1) begin
            chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                exp_done_cnt++;
                chk({tag, "_quotient"}, bus.quotient, e.q);
                chk({tag, "_remainder"}, bus.remainder, e.r);
                chk({tag, "_div_by_zero"}, bus.div_by_zero, e.z);
                chk({tag, "_busy_in_done"}, bus.busy, 1);
            end
        end
        tick();
        chk({tag, "_done_low_after"}, bus.done, 0);
        chk({tag, "_idle_after"}, bus.busy, 0);
        chk({tag, "_done_pulses"}, done_cnt, exp_done_cnt);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        done_cnt     = 0;
        exp_done_cnt = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        rst = 1'b0;
        tick();

        // 13/3: DONE entered at E5.
        start_op(13, 3, 4, 1, 0);
        finish_op("d13_3", 5, 0);

        // 63/1: worst-case latency.
        start_op(63, 1, 63, 0, 0);
        finish_op("d63_1", 64, 0);

        // Zero dividend and dividend smaller than divisor.
        start_op(0, 2, 0, 0, 0);
        finish_op("d0_2", 1, 0);
        start_op(2, 3, 0, 2, 0);
        finish_op("d2_3", 1, 0);

        // Divide by zero, then a normal divide clears the flag.
        start_op(7, 0, 63, 0, 1);
        finish_op("d7_0", 0, 0);
        start_op(7, 2, 3, 1, 0);
        finish_op("d7_2", 4, 0);

        // 20/3 with a 9/2 request held through RUN and DONE; only one result,
        // and the 9/2 is taken on the following IDLE cycle.
        start_op(20, 3, 6, 2, 0);
        finish_op("d20_3", 7, 1);
        start_op(9, 2, 4, 1, 0);
        finish_op("d9_2", 5, 0);

        // Reset mid-RUN of 50/1: operation discarded, no done pulse.
        bus.start    = 1'b1;
        bus.dividend = WIDTH'(50);
        bus.divisor  = DW'(1);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("midrun_busy_before_rst", bus.busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun_rst_busy", bus.busy, 0);
        chk("midrun_rst_done", bus.done, 0);
        chk("midrun_rst_quotient", bus.quotient, 0);
        chk("midrun_rst_remainder", bus.remainder, 0);
        for (int i = 0; i < 60; i++) tick();
        chk("midrun_no_done_pulse", done_cnt, exp_done_cnt);

        start_op(10, 3, 3, 1, 0);
        finish_op("d10_3", 4, 0);

        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
